// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word transmitter and its byte-level sender.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    typedef enum logic {
        W_IDLE,
        W_BUSY
    } word_state_t;

    function automatic int baud_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_word_transmit_if.sv
// Word handshake between a producer and the UART word transmitter.
interface uart_word_transmit_if #(
    parameter int WIDTH = 16
);
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;

    modport master (output valid_in, output data_in, input ready_out);
    modport slave  (input valid_in, input data_in, output ready_out);
endinterface

// File: rtl/uart_transmit.sv
// Single-byte 8N1 sender with its own baud counter.
// Ready rises in the last stop-bit cycle so a following byte starts with no idle gap.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       ready_out,
    output logic       done_out,
    output logic       tx_wire_out
);

    localparam int BAUD_PERIOD = baud_period(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W       = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_PERIOD - 1);

    tx_state_t  r_state, w_state_next;
    logic [CNT_W-1:0] r_baud_cnt, w_baud_next;
    logic [2:0] r_bit_idx, w_bit_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_tx, w_tx_next;
    logic       r_done, w_done_next;
    logic       w_bit_end;

    assign w_bit_end   = (r_baud_cnt == CNT_LAST);
    assign ready_out   = !rst_in && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    assign done_out    = r_done;
    assign tx_wire_out = r_tx;

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_done_next  = 1'b0;
        w_tx_next    = 1'b1;

        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_state_next = START;
                    w_shift_next = data_in;
                    w_baud_next  = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_bit_next   = 3'd0;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    w_done_next = 1'b1;
                    // A byte offered in the final stop cycle chains straight into its start bit.
                    if (valid_in) begin
                        w_state_next = START;
                        w_shift_next = data_in;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[w_bit_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
        end
    end

endmodule

// File: rtl/uart_word_transmit.sv
// Byte sequencer: sends a WIDTH-bit word as back-to-back 8N1 frames, MSB byte first.
module uart_word_transmit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int WIDTH     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    uart_word_transmit_if.slave  bus,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 tx_wire_out
);

    localparam int NUM_BYTES = WIDTH / UART_DATA_BITS;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

    word_state_t      r_state, w_state_next;
    logic [WIDTH-1:0] r_word, w_word_next;
    logic [IDX_W-1:0] r_byte_idx, w_byte_idx_next;
    logic             w_ready;
    logic             w_sub_valid;
    logic [7:0]       w_sub_data;
    logic             w_sub_ready;
    logic             w_sub_done;

    assign w_ready       = (r_state == W_IDLE) && !rst_in;
    assign bus.ready_out = w_ready;
    assign busy_out      = (r_state == W_BUSY);
    // The byte sender's done pulse only counts once the sequencer has returned to idle.
    assign done_out      = w_sub_done && (r_state == W_IDLE);

    always_comb begin
        w_state_next    = r_state;
        w_word_next     = r_word;
        w_byte_idx_next = r_byte_idx;
        w_sub_valid     = 1'b0;
        w_sub_data      = r_word[WIDTH-1 -: 8];

        case (r_state)
            W_IDLE: begin
                w_sub_valid = bus.valid_in && w_ready;
                w_sub_data  = bus.data_in[WIDTH-1 -: 8];
                if (bus.valid_in && w_ready) begin
                    w_state_next    = W_BUSY;
                    w_word_next     = bus.data_in << 8;
                    w_byte_idx_next = '0;
                end
            end
            W_BUSY: begin
                if (w_sub_ready) begin
                    if (r_byte_idx == IDX_LAST) begin
                        w_state_next = W_IDLE;
                    end else begin
                        w_sub_valid     = 1'b1;
                        w_word_next     = r_word << 8;
                        w_byte_idx_next = r_byte_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= W_IDLE;
            r_word     <= '0;
            r_byte_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_word     <= w_word_next;
            r_byte_idx <= w_byte_idx_next;
        end
    end

    uart_transmit #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_byte_tx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (w_sub_valid),
        .data_in     (w_sub_data),
        .ready_out   (w_sub_ready),
        .done_out    (w_sub_done),
        .tx_wire_out (tx_wire_out)
    );

endmodule
